pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed 32-bit IF/ID stage register.
- Generic inter-stage pipeline register carrying {pc, inst} with a valid/ready handshake, a 2-entry skid buffer, flush, and bubble (nop) indication.
- Used between any two pipeline stages (IF/ID, ID/EX, ...). Sustains 1 transfer/cycle with registered in_ready, so downstream stall does not combinationally reach upstream.

Parameters:
- PC_W, 32, width of pc field
- INST_W, 32, width of instruction/payload field
- NOP_INST, 0, value driven on out_inst when no valid entry (bubble)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous reset, active-high
- flush  in  1  synchronous clear of stage contents (branch/jump redirect)
- in_valid  in  1  upstream offers {in_pc, in_inst}
- in_ready  out  1  stage can accept this cycle (registered)
- in_pc  in  PC_W  upstream pc
- in_inst  in  INST_W  upstream instruction
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream consumes head this cycle
- out_pc  out  PC_W  head pc, 0 when empty
- out_inst  out  INST_W  head inst, NOP_INST when empty
- out_nop  out  1  bubble flag, equals ~out_valid

Behaviour:
- Storage: main entry (drives outputs) + skid entry. FIFO order always preserved.
- States: EMPTY (none valid), ONE (main valid), TWO (main+skid valid).
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- in_ready = 1 in EMPTY/ONE, 0 in TWO; registered, derived from next state.
- EMPTY: accept -> ONE, main <= input. Otherwise stays.
- ONE: accept & drain -> ONE, main <= input; accept & ~drain -> TWO, skid <= input; ~accept & drain -> EMPTY; else hold.
- TWO: drain -> ONE, main <= skid. No accept possible.
- Latency: input accepted at edge N appears on outputs after edge N (1 cycle) when EMPTY or draining.
- Empty outputs: out_pc=0, out_inst=NOP_INST, out_valid=0, out_nop=1.
- rst (priority over everything): -> EMPTY, all payload registers cleared (pc 0, inst NOP_INST), in_ready=1 next cycle.
- flush (priority below rst, above handshake): same effect as rst. An input offered in the flush cycle is dropped even if in_ready=1; a head drained in the flush cycle counts as consumed by downstream.
- No stall input: stall is expressed solely as out_ready=0. Payload holds stable while out_valid & ~out_ready.
- in_valid while in_ready=0: ignored; upstream must hold its data.
- Initial (pre-reset) simulation state equals reset state.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments on each cycle with out_valid & ~out_ready.
  - flush_cnt increments on each flush cycle.
  - Both saturate at all-ones and clear on rst only (not on flush).
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding (ST_EMPTY=0, ST_ONE=1, ST_TWO=2)
  - NOP_INST default 32'h00000013 (RV32I addi x0,x0,0) available as a constant; module default stays 0 for compatibility.
- Single natural sub-module: pipe_entry_reg, a valid+payload register with load/clear enables, instantiated twice (main, skid).

Test Plan:
- Reset: assert rst 2 cycles -> out_valid=0, out_nop=1, out_pc=0, out_inst=NOP_INST, in_ready=1.
- Streaming: in_valid=1 with pc 0x0,0x4,0x8,... and out_ready=1 -> outputs follow input by 1 cycle, one per cycle, no gaps.
- Backpressure: load pc 0x100, 0x104; out_ready=0 -> state TWO, in_ready=0, out_pc holds 0x100. Release -> 0x100 then 0x104, order intact.
- Flush with full skid: state TWO plus flush=1 and in_valid pc 0x200 -> next cycle EMPTY, out_nop=1, 0x200 dropped, in_ready=1.
- Simultaneous: state ONE (pc 0x10), accept 0x14 and drain same cycle -> out_pc=0x14, state ONE, no skid use.
- PIPE_STAGE_PERF_EN: 5 cycles out_valid & ~out_ready plus 2 flushes -> stall_cnt=5, flush_cnt=2. rst -> both 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: FSM encoding,
// the RV32I canonical nop and small helpers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

  function automatic logic can_accept(input state_e s);
    return (s != ST_TWO);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) begin
      return v + 32'd1;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One storage slot of the stage: valid bit plus payload, with a clear that
// wins over load and restores the payload to its bubble value.
module pipe_entry_reg #(
  parameter int            W       = 64,
  parameter logic [W-1:0]  CLR_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q = 1'b0;
  logic [W-1:0] data_q  = CLR_VAL;

  // Slot update: clear has priority over load, otherwise hold.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      valid_q <= 1'b0;
      data_q  <= CLR_VAL;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= d_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register {pc, inst} with valid/ready, 2-entry skid and flush.
// Optional PIPE_STAGE_PERF_EN adds saturating stall/flush counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                 PC_W     = 32,
  parameter int                 INST_W   = 32,
  parameter logic [INST_W-1:0]  NOP_INST = {INST_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              out_nop
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam int               ENT_W   = PC_W + INST_W;
  localparam logic [ENT_W-1:0] CLR_VAL = {{PC_W{1'b0}}, NOP_INST};

  state_e state_q    = ST_EMPTY;
  state_e state_d;
  logic   in_ready_q = 1'b1;
  logic   nop_q      = 1'b1;

  logic             accept_s, drain_s;
  logic             main_load_s, main_clr_s, main_from_skid_s;
  logic             skid_load_s, skid_clr_s;
  logic             main_valid_s, skid_valid_s;
  logic [ENT_W-1:0] main_data_s, skid_data_s, main_d_s;

  assign accept_s = in_valid & in_ready_q;
  assign drain_s  = main_valid_s & out_ready;
  assign main_d_s = main_from_skid_s ? skid_data_s : {in_pc, in_inst};

  // Next-state and slot strobes; rst and flush both empty the stage.
  always_comb begin
    state_d          = state_q;
    main_load_s      = 1'b0;
    main_clr_s       = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    skid_clr_s       = 1'b0;
    if (rst || flush) begin
      state_d    = ST_EMPTY;
      main_clr_s = 1'b1;
      skid_clr_s = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            state_d     = ST_ONE;
            main_load_s = 1'b1;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && drain_s) begin
            main_load_s = 1'b1;
          end else if (accept_s) begin
            state_d     = ST_TWO;
            skid_load_s = 1'b1;
          end else if (drain_s) begin
            state_d    = ST_EMPTY;
            main_clr_s = 1'b1;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (drain_s) begin
            state_d          = ST_ONE;
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
            skid_clr_s       = 1'b1;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d    = ST_EMPTY;
          main_clr_s = 1'b1;
          skid_clr_s = 1'b1;
        end
      endcase
    end
  end

  // State register; in_ready and bubble flag are registered from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      nop_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= can_accept(state_d);
      nop_q      <= (state_d == ST_EMPTY);
    end
  end

  pipe_entry_reg #(.W(ENT_W), .CLR_VAL(CLR_VAL)) u_main (
    .clk     (clk),
    .load_i  (main_load_s),
    .clr_i   (main_clr_s),
    .d_i     (main_d_s),
    .valid_o (main_valid_s),
    .data_o  (main_data_s)
  );

  pipe_entry_reg #(.W(ENT_W), .CLR_VAL(CLR_VAL)) u_skid (
    .clk     (clk),
    .load_i  (skid_load_s),
    .clr_i   (skid_clr_s),
    .d_i     ({in_pc, in_inst}),
    .valid_o (skid_valid_s),
    .data_o  (skid_data_s)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_s;
  assign out_nop   = nop_q;
  assign out_pc    = main_data_s[ENT_W-1:INST_W];
  assign out_inst  = main_data_s[INST_W-1:0];

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q = 32'd0;
  logic [31:0] flush_cnt_q = 32'd0;

  // Saturating event counters; flush does not clear them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= sat_inc32(stall_cnt_q, main_valid_s & ~out_ready);
      flush_cnt_q <= sat_inc32(flush_cnt_q, flush);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  logic unused_skid_s;
  assign unused_skid_s = skid_valid_s;
`else
  logic unused_skid_s;
  assign unused_skid_s = skid_valid_s;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomized + directed bench for pipe_stage_skid against a queue-based model.
// Honours PIPE_STAGE_PERF_EN for the counter ports.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam logic [31:0] NOP = RV32I_NOP;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_nop;
  logic [31:0] in_pc, in_inst, out_pc, out_inst;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_skid #(.PC_W(32), .INST_W(32), .NOP_INST(NOP)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_nop   (out_nop)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];
  logic        m_ready = 1'b1;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic        e_valid;
    logic [31:0] e_pc, e_inst;
    e_valid = (q.size() > 0);
    e_pc    = e_valid ? q[0].pc : 32'd0;
    e_inst  = e_valid ? q[0].inst : NOP;
    check("out_valid", out_valid, e_valid);
    check("out_nop", out_nop, !e_valid);
    check("out_pc", out_pc, e_pc);
    check("out_inst", out_inst, e_inst);
    check("in_ready", in_ready, m_ready);
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);
`endif
  endtask

  // One clock: drive, update the FIFO model at the edge, check half a cycle later.
  task automatic cycle(input logic r, input logic f, input logic iv,
                       input logic [31:0] pc, input logic [31:0] inst, input logic ordy);
    ent_t e;
    logic acc, drn;
    rst = r; flush = f; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
    @(posedge clk);
    if (r) begin
      m_stall = 32'd0;
      m_flush = 32'd0;
    end else begin
      if (q.size() > 0 && !ordy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (f && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 32'd1;
    end
    if (r || f) begin
      q.delete();
    end else begin
      acc = iv && m_ready;
      drn = (q.size() > 0) && ordy;
      if (drn) void'(q.pop_front());
      if (acc) begin
        e.pc = pc; e.inst = inst;
        q.push_back(e);
      end
    end
    m_ready = (q.size() < 2);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = 32'd0; in_inst = 32'd0; out_ready = 1'b0;

    cycle(1'b1, 1'b0, 1'b1, 32'h55, 32'h66, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'h77, 32'h88, 1'b0);
    check("rst_nop", out_nop, 1'b1);
    check("rst_inst", out_inst, NOP);
    check("rst_ready", in_ready, 1'b1);

    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, 32'(i * 4), $urandom, 1'b1);
    check("stream_last", out_pc, 32'h1C);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);

    cycle(1'b0, 1'b0, 1'b1, 32'h100, 32'hA0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h104, 32'hA4, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h108, 32'hA8, 1'b0);
    check("bp_ready", in_ready, 1'b0);
    check("bp_hold", out_pc, 32'h100);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    check("bp_second", out_pc, 32'h104);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    check("bp_empty", out_valid, 1'b0);

    cycle(1'b0, 1'b0, 1'b1, 32'h1F8, 32'hB0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h1FC, 32'hB4, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h200, 32'hB8, 1'b0);
    check("fl_nop", out_nop, 1'b1);
    check("fl_ready", in_ready, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    check("fl_dropped", out_valid, 1'b0);

    cycle(1'b0, 1'b0, 1'b1, 32'h10, 32'hC0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'h14, 32'hC4, 1'b1);
    check("sim_pc", out_pc, 32'h14);
    check("sim_ready", in_ready, 1'b1);

`ifdef PIPE_STAGE_PERF_EN
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'h300, 32'hD0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    check("perf_stall", stall_cnt, 32'd5);
    check("perf_flush", flush_cnt, 32'd2);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    check("perf_rst_stall", stall_cnt, 32'd0);
    check("perf_rst_flush", flush_cnt, 32'd0);
`endif

    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(99) == 0), ($urandom_range(99) < 3),
            ($urandom_range(99) < 60), $urandom, $urandom,
            ($urandom_range(99) < 60));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
